// File: rtl/uart_rx_sniffer.sv
// UART receive monitor: 2-FF synchronizer, oversampling 8N1 frame decoder, show-ahead
// byte FIFO and sticky error flags. Define UART_SNIFF_PARITY_EN for 8E1 frames.
module uart_rx_sniffer #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        rx,
    input  logic                        rd_en,
    input  logic                        clr,
    output logic [7:0]                  rd_data,
    output logic                        rd_valid,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic [7:0]                  last_byte,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overflow
);
    localparam int CPB  = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int HALF = CPB / 2;
    localparam int TW   = $clog2(CPB);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CPB - 1);
    localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

`ifdef UART_SNIFF_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t          state, state_nx;
    logic            rx_meta, rxs, rxs_d, fall, expire;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg, push_byte;
    logic            push_q, par_fail;
    logic            load_half, load_full, shift_en, push_req, frame_set;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            full, pop, wr, ovf_set;

    // Synchronizer idles high so reset never looks like a start bit
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) {rx_meta, rxs, rxs_d} <= 3'b111;
        else          {rx_meta, rxs, rxs_d} <= {rx, rx_meta, rxs};
    end

    assign fall   = rxs_d & ~rxs;
    assign expire = (timer == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (fall) state_nx = START;
            START:     if (expire) state_nx = rxs ? IDLE : DATA;
`ifdef UART_SNIFF_PARITY_EN
            DATA:      if (expire && bit_idx == 3'd7) state_nx = PARITY;
            PARITY:    if (expire) state_nx = STOP;
`else
            DATA:      if (expire && bit_idx == 3'd7) state_nx = STOP;
`endif
            STOP:      if (expire) state_nx = rxs ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rxs) state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

`ifdef UART_SNIFF_PARITY_EN
    logic par_set;
`endif

    always_comb begin
        load_half = 1'b0;
        load_full = 1'b0;
        shift_en  = 1'b0;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            IDLE:  load_half = fall;
            START: load_full = expire & ~rxs;
            DATA: begin
                load_full = expire;
                shift_en  = expire;
            end
`ifdef UART_SNIFF_PARITY_EN
            PARITY: begin
                load_full = expire;
                par_set   = expire & (^shreg ^ rxs);
            end
`endif
            STOP: begin
                push_req  = expire & rxs & ~par_fail;
                frame_set = expire & ~rxs;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            push_q    <= 1'b0;
            push_byte <= '0;
        end else begin
            if (load_half)      timer <= T_HALF;
            else if (load_full) timer <= T_FULL;
            else if (!expire)   timer <= timer - 1'b1;
            if (load_half)      bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + 1'b1;
            if (shift_en)       shreg <= {rxs, shreg[7:1]};
            push_q <= push_req;
            if (push_req)       push_byte <= shreg;
        end
    end

`ifdef UART_SNIFF_PARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            par_fail   <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (load_half)    par_fail <= 1'b0;
            else if (par_set) par_fail <= 1'b1;
            parity_err <= par_set | (parity_err & ~clr);
        end
    end
`else
    assign par_fail   = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A pop in the push cycle frees the slot the new byte lands in
    assign full    = (count == C_FULL);
    assign pop     = rd_en & rd_valid;
    assign wr      = push_q & (~full | pop);
    assign ovf_set = push_q & full & ~pop;

    always_ff @(posedge clock) begin
        if (wr) mem[wr_ptr] <= push_byte;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_byte <= 8'h00;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_byte <= push_byte;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            frame_err <= frame_set | (frame_err & ~clr);
            overflow  <= ovf_set | (overflow & ~clr);
        end
    end

    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Directed bench for uart_rx_sniffer: frame-level queue model compared every cycle,
// plus literal checks at the key points. Runs at 1 Mbaud (CPB=50) to keep runs short.
module tb_uart_rx_sniffer;
    localparam int CPB   = 50;            // (50e6 + 5e5) / 1e6
    localparam int HALF  = 25;
`ifdef UART_SNIFF_PARITY_EN
    localparam int PB    = 1;
`else
    localparam int PB    = 0;
`endif
    // 2 sync stages + 1 edge-detect register, half bit, then one bit time per slot
    localparam int SAMP  = 3 + HALF + (9 + PB) * CPB;
    localparam int DEPTH = 16;
    localparam int GAP   = 20;
    localparam int EV_PUSH = 0, EV_FE = 1, EV_PE = 2;

    logic       clock = 1'b0, reset_n = 1'b0, rx = 1'b1, rd_en = 1'b0, clr = 1'b0;
    logic [7:0] rd_data, last_byte;
    logic [4:0] count;
    logic       rd_valid, frame_err, parity_err, overflow;

    uart_rx_sniffer #(.CLK_HZ(50000000), .BAUD(1000000), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .rx(rx), .rd_en(rd_en), .clr(clr),
        .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .last_byte(last_byte),
        .frame_err(frame_err), .parity_err(parity_err), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct { int left; int kind; logic [7:0] b; } ev_t;
    ev_t        ev[$];
    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00, e_data;
    bit         m_fe = 0, m_pe = 0, m_ov = 0, m_pop, m_full, e_valid, ok;
    int         n_chk = 0, n_pass = 0;

    // Model: pops and flag events resolve at the clock edge they are due on
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            ev.delete();
            m_last = 8'h00;
            m_fe = 0; m_pe = 0; m_ov = 0;
        end else begin
            m_pop  = rd_en && mq.size() != 0;
            m_full = mq.size() >= DEPTH;
            if (m_pop) void'(mq.pop_front());
            if (clr) begin m_fe = 0; m_pe = 0; m_ov = 0; end
            for (int i = 0; i < ev.size(); i++) ev[i].left = ev[i].left - 1;
            while (ev.size() != 0 && ev[0].left <= 0) begin
                case (ev[0].kind)
                    EV_FE:   m_fe = 1;
                    EV_PE:   m_pe = 1;
                    default:
                        if (!m_full || m_pop) begin
                            mq.push_back(ev[0].b);
                            m_last = ev[0].b;
                        end else m_ov = 1;
                endcase
                void'(ev.pop_front());
            end
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            e_valid = mq.size() != 0;
            e_data  = e_valid ? mq[0] : 8'h00;
            ok = (count == 5'(mq.size())) && (rd_valid == e_valid) &&
                 (!e_valid || rd_data == e_data) && (last_byte == m_last) &&
                 (frame_err == m_fe) && (parity_err == m_pe) && (overflow == m_ov);
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL cycle t=%0t got/want: count %0d/%0d valid %0b/%0b data %h/%h last %h/%h fe %0b/%0b pe %0b/%0b ov %0b/%0b",
                          $time, count, mq.size(), rd_valid, e_valid, rd_data, e_data,
                          last_byte, m_last, frame_err, m_fe, parity_err, m_pe, overflow, m_ov);
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic pop;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Drives one frame starting now; extra low time after a bad stop bit is 'hold'
    task automatic send_frame(input logic [7:0] b, input bit stop, input bit bad_par, input int hold);
        rx = 1'b0;
        if (PB == 1 && bad_par) ev.push_back('{SAMP - CPB, EV_PE, b});
        if (!stop) ev.push_back('{SAMP, EV_FE, b});
        else if (!(PB == 1 && bad_par)) ev.push_back('{SAMP + 1, EV_PUSH, b});
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        if (PB == 1) begin
            rx = ^b ^ bad_par;
            repeat (CPB) tick();
        end
        rx = stop;
        repeat (CPB) tick();
        if (!stop) repeat (hold) tick();
        rx = 1'b1;
        repeat (GAP) tick();
    endtask

    initial begin
        repeat (3) tick();
        check("reset count", 32'(count), 0);
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset last_byte", 32'(last_byte), 0);
        check("reset frame_err", 32'(frame_err), 0);
        check("reset parity_err", 32'(parity_err), 0);
        check("reset overflow", 32'(overflow), 0);
        reset_n = 1'b1;
        repeat (5) tick();

        // Single byte with exact push latency
        fork
            send_frame(8'hA5, 1, 0, 0);
            begin
                repeat (SAMP) tick();
                check("pre-push count", 32'(count), 0);
                tick();
                check("push count", 32'(count), 1);
                check("push rd_data", 32'(rd_data), 'hA5);
                check("push last_byte", 32'(last_byte), 'hA5);
            end
        join

        // False start shorter than half a bit
        rx = 1'b0;
        repeat (HALF / 2) tick();
        rx = 1'b1;
        repeat (2 * CPB) tick();
        check("glitch count", 32'(count), 1);
        send_frame(8'h3C, 1, 0, 0);
        check("after glitch last", 32'(last_byte), 'h3C);

        // Framing error with clr on the same edge: set wins
        fork
            send_frame(8'h55, 0, 0, CPB);
            begin
                repeat (SAMP - 1) tick();
                clr = 1'b1;
                tick();
                clr = 1'b0;
            end
        join
        check("frame_err set", 32'(frame_err), 1);
        check("frame_err count", 32'(count), 2);
        send_frame(8'h0F, 1, 0, 0);
        check("after break last", 32'(last_byte), 'h0F);
        pulse_clr();
        tick();
        check("frame_err cleared", 32'(frame_err), 0);
        check("drain0", 32'(rd_data), 'hA5); pop();
        check("drain1", 32'(rd_data), 'h3C); pop();
        check("drain2", 32'(rd_data), 'h0F); pop();
        check("drained valid", 32'(rd_valid), 0);
        pop();
        check("empty pop count", 32'(count), 0);

        // Overflow: 17 bytes, no reads
        for (int i = 0; i <= 16; i++) send_frame(8'(i), 1, 0, 0);
        check("ovf count", 32'(count), 16);
        check("ovf flag", 32'(overflow), 1);
        check("ovf last unchanged", 32'(last_byte), 'h0F);
        for (int i = 0; i < 16; i++) begin
            check("ovf drain", 32'(rd_data), 32'(i));
            pop();
        end
        check("ovf drained valid", 32'(rd_valid), 0);

        // Full FIFO with a pop in the push cycle
        pulse_clr();
        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1, 0, 0);
        fork
            send_frame(8'h77, 1, 0, 0);
            begin
                repeat (SAMP) tick();
                rd_en = 1'b1;
                tick();
                rd_en = 1'b0;
            end
        join
        check("fullpop overflow", 32'(overflow), 0);
        check("fullpop count", 32'(count), 16);
        check("fullpop last", 32'(last_byte), 'h77);
        for (int i = 1; i < 16; i++) begin
            check("fullpop drain", 32'(rd_data), 32'('h20 + i));
            pop();
        end
        check("fullpop tail", 32'(rd_data), 'h77);
        pop();
        check("fullpop empty", 32'(rd_valid), 0);

`ifdef UART_SNIFF_PARITY_EN
        send_frame(8'h03, 1, 0, 0);
        check("parity ok count", 32'(count), 1);
        send_frame(8'h03, 1, 1, 0);
        check("parity_err set", 32'(parity_err), 1);
        check("parity bad count", 32'(count), 1);
        check("parity frame_err", 32'(frame_err), 0);
        pop();
        pulse_clr();
`endif

        // Reset in the middle of a frame
        send_frame(8'h5A, 1, 0, 0);
        check("pre-abort count", 32'(count), 1);
        rx = 1'b0;
        repeat (3 * CPB) tick();
        reset_n = 1'b0;
        rx = 1'b1;
        #1;
        check("abort count", 32'(count), 0);
        check("abort valid", 32'(rd_valid), 0);
        check("abort last", 32'(last_byte), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (12 * CPB) tick();
        check("abort no push", 32'(count), 0);
        check("abort no flag", 32'(frame_err), 0);
        send_frame(8'hC3, 1, 0, 0);
        check("recover data", 32'(rd_data), 'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_sniffer.md
# uart_rx_sniffer

- Receive-side monitor for the FlexPRET UART transmit line on the DE1-SoC.
- Sits downstream of the core's `io_uart_tx` (the net also driven to GPIO_0[0]).
- Oversamples the line, decodes 8-bit frames, buffers them in a show-ahead FIFO, and reports framing, parity and overflow errors.
- Lets on-board logic (LEDR, a future HEX driver or a debug bridge) consume console output without an external USB-UART.

## Interface
Parameters:
- `CLK_HZ`, 50000000, input clock frequency in Hz
- `BAUD`, 115200, line rate
- `FIFO_DEPTH`, 16, byte entries; power of two, minimum 2

Ports:
- `clock`  in  1  system clock (CLOCK_50)
- `reset_n`  in  1  asynchronous, active-low reset (driven directly from KEY[3])
- `rx`  in  1  serial line, asynchronous to `clock`, idle high
- `rd_en`  in  1  pop head byte
- `clr`  in  1  clear sticky error flags
- `rd_data`  out  8  FIFO head byte, valid while `rd_valid`
- `rd_valid`  out  1  FIFO not empty
- `count`  out  $clog2(FIFO_DEPTH)+1  bytes held
- `last_byte`  out  8  most recently accepted byte (for LEDR)
- `frame_err`  out  1  sticky, stop bit sampled low
- `parity_err`  out  1  sticky, parity mismatch
- `overflow`  out  1  sticky, byte dropped on a full FIFO

## Operation
- `rx` passes through a 2-FF synchronizer; the synchronizer resets to 1. All decoding uses the synchronized `rxs`.
- Derived constants:
  - CPB = (CLK_HZ + BAUD/2) / BAUD, which is 434 at the defaults.
  - HALF = CPB/2, which is 217.
  - The bit timer is $clog2(CPB) bits wide.
- FSM states are IDLE, START, DATA, PARITY (only with the macro), STOP and WAIT_HIGH.
- IDLE:
  - A falling edge on `rxs` loads the timer with HALF-1 and enters START.
- START:
  - At timer expiry, sample `rxs`.
  - If the sample is 1, it is a false start: return to IDLE with no flag.
  - If the sample is 0, load CPB-1, clear the bit index, and enter DATA.
- DATA:
  - At each expiry, shift `rxs` into bit [7] (LSB first) and reload CPB-1.
  - After the 8th bit, go to PARITY if compiled in, otherwise to STOP.
- STOP:
  - At expiry, sample `rxs`.
  - If the sample is 1 and no parity error occurred: push the byte and return to IDLE.
  - If the sample is 0: set `frame_err`, discard the byte, and enter WAIT_HIGH.
  - If the sample is 1 but parity failed: discard the byte and return to IDLE.
- WAIT_HIGH stays until `rxs` = 1, then returns to IDLE. This prevents a break condition from being taken as a start bit.
- Push:
  - If `count` < FIFO_DEPTH, or a pop occurs in the same cycle, the byte is written and `last_byte` updates.
  - Otherwise the byte is dropped, `overflow` is set, and `last_byte` is unchanged.
- Pop:
  - `rd_en` with `rd_valid`=1 advances the read pointer.
  - `rd_en` on an empty FIFO is ignored.
- Simultaneous push and pop: `count` is unchanged and pointers wrap modulo FIFO_DEPTH.
- `clr` clears all three sticky flags. If an error event fires in the same cycle, the set wins.
- `clr` does not affect the FIFO or the FSM.

## Timing
- On reset: FSM is IDLE, pointers are 0, `count`=0, `rd_valid`=0, `rd_data` is don't-care, `last_byte`=8'h00, and all flags are 0.
- Latency from the `rx` falling edge:
  - 2 cycles of synchronizer delay.
  - The stop sample falls at about HALF + 9·CPB cycles, or HALF + 10·CPB with parity.
- Push timing:
  - The push is registered on the stop-sample edge.
  - `rd_valid`, `count` and `last_byte` update on the following edge.
  - `rd_data` is valid in the same cycle as `rd_valid`.
- `rd_data` reflects the new head one cycle after a pop.
- Asserting `reset_n` mid-frame aborts immediately. The FIFO contents are lost, and the partial frame is neither flagged nor pushed.

## Configuration
- `UART_SNIFF_PARITY_EN`
  - Defined: frames are 8E1. The PARITY state samples the bit after D7.
  - Defined, mismatch: if the XOR of data and parity ≠ 0, set `parity_err`. The byte is discarded after the stop check, and `frame_err` still applies independently.
  - Undefined: frames are 8N1, the PARITY state is not built, and `parity_err` is tied 0.

## Test plan
All scenarios use the defaults, so CPB=434.
- **Single byte:** drive 8'hA5 as 8N1 → `rd_valid` rises about 4123 cycles after the start edge, `rd_data`=8'hA5, `last_byte`=8'hA5, `count`=1, no flags.
- **False start:** drive a 100-cycle low glitch → FSM returns to IDLE, `count`=0, no flags. A following 8'h3C is then received correctly.
- **Framing error:** drive 8'h55 with the stop bit low, held low for 2·CPB → `frame_err`=1, `count`=0. The next 8'h0F is received only after `rx` returns high. Pulsing `clr` clears `frame_err`.
- **Overflow:** send 17 bytes 8'h00..8'h10 with no reads → `count`=16 and `overflow`=1. Reading drains 8'h00..8'h0F in order, then `rd_valid`=0.
- **Full with pop:** with the FIFO full, assert `rd_en` in the cycle of the 17th push → no overflow, `count` stays 16, and the tail holds the new byte.
- **Parity** (macro defined): 8'h03 with parity 0 is accepted. 8'h03 with parity 1 → `parity_err`=1 and `count` unchanged.
